// File: rtl/cpu_bus_trace.sv
// -----------------------------------------------------------------------------
// cpu_bus_trace
//
// On-chip trace buffer that snoops the cpu_top memory bus. Qualified bus
// cycles are stamped with a cycle count and written into a circular buffer.
// Capture stops on an address trigger followed by a post-trigger count, on
// CPU halt, or on a watchdog timeout. Once stopped, the frozen trace is read
// out oldest-first.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   addr_bus, data_bus   snooped address bus and memory read data
//   wr_data              CPU write data (acc_out)
//   mem_read, mem_write  bus strobes
//   halt                 CPU halt
//   arm                  one-cycle start pulse (honoured in IDLE/DONE only)
//   mode                 bit0 capture reads, bit1 capture writes
//   trig_addr, trig_mask trigger address and compare mask (1 = bit compared)
//   post_count           entries to capture after the trigger entry
//   timeout_limit        watchdog limit in cycles, 0 disables
//   rd_en                pop request
//   rd_data, rd_valid    popped entry {cyc, addr, data, wr, rd} and its pulse
//   state                0 IDLE, 1 PRE, 2 POST, 3 DONE
//   count                entries held
//   dropped              entries overwritten, saturating
//   triggered, halted, timed_out   causes of entering DONE
// -----------------------------------------------------------------------------
module cpu_bus_trace #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int CYC_W   = 16,
   parameter int ENTRY_W = CYC_W + ADDR_W + DATA_W + 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDR_W-1:0]        addr_bus,
   input  logic [DATA_W-1:0]        data_bus,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     mem_read,
   input  logic                     mem_write,
   input  logic                     halt,
   input  logic                     arm,
   input  logic [1:0]               mode,
   input  logic [ADDR_W-1:0]        trig_addr,
   input  logic [ADDR_W-1:0]        trig_mask,
   input  logic [$clog2(DEPTH):0]   post_count,
   input  logic [CYC_W-1:0]         timeout_limit,
   input  logic                     rd_en,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic                     rd_valid,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CYC_W-1:0]         dropped,
   output logic                     triggered,
   output logic                     halted,
   output logic                     timed_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CYC_W-1:0]   cyc;
   logic [CNT_W-1:0]   remaining;

   logic               capturing;
   logic               qual;
   logic               wr_en;
   logic               trig_hit;
   logic               halt_stop;
   logic               tmo_stop;
   logic               post_done;
   logic               arm_ok;
   logic               pop;
   logic [DATA_W-1:0]  cap_data;
   logic [ENTRY_W-1:0] entry;

   assign state = state_q;

   // Bus qualification and the entry that a qualified cycle would write.
   assign capturing = (state_q == S_PRE) || (state_q == S_POST);
   assign qual      = (mem_read & mode[0]) | (mem_write & mode[1]);
   assign wr_en     = capturing & qual;
   assign cap_data  = mem_write ? wr_data : data_bus;
   assign entry     = {cyc, addr_bus, cap_data, mem_write, mem_read};

   // Stop causes. Several may fire on the same cycle; each sets its own flag.
   assign trig_hit  = (state_q == S_PRE) && qual &&
                      (((addr_bus ^ trig_addr) & trig_mask) == '0);
   assign halt_stop = capturing && halt;
   assign tmo_stop  = capturing && (timeout_limit != '0) && (cyc == timeout_limit);
   // remaining is never 0 while in POST, so the write that brings it from 1
   // to 0 is the last one.
   assign post_done = (state_q == S_POST) && qual && (remaining == CNT_W'(1));

   // Readout handshake: rd_en is a request sampled on a clock edge while the
   // trace is frozen (DONE). If an entry is held, rd_data carries the oldest
   // entry and rd_valid pulses high for exactly one cycle after that edge;
   // with nothing held, rd_valid stays low. rd_en has no effect elsewhere, and
   // an arm on the same edge takes precedence over the pop.
   assign arm_ok = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign pop    = (state_q == S_DONE) && rd_en && (count != '0) && !arm;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (arm) state_d = S_PRE;
         end
         S_PRE: begin
            if (halt_stop || tmo_stop || (trig_hit && (post_count == '0)))
               state_d = S_DONE;
            else if (trig_hit)
               state_d = S_POST;
         end
         S_POST: begin
            if (halt_stop || tmo_stop || post_done)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (arm) state_d = S_PRE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Entry storage has no reset: contents are only visible through pointers
   // that reset and arm clear.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   // Pointers, occupancy, counters, flags and readout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dropped   <= '0;
         cyc       <= '0;
         remaining <= '0;
         triggered <= 1'b0;
         halted    <= 1'b0;
         timed_out <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_valid <= pop;
         if (pop) rd_data <= mem[rd_ptr];

         if (arm_ok) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dropped   <= '0;
            cyc       <= '0;
            remaining <= '0;
            triggered <= 1'b0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
         end else begin
            // Entries take the pre-increment stamp, so the first capture
            // cycle after arm stamps 0.
            if (capturing && (cyc != CYC_MAX)) cyc <= cyc + 1'b1;

            if (trig_hit)  triggered <= 1'b1;
            if (halt_stop) halted    <= 1'b1;
            if (tmo_stop)  timed_out <= 1'b1;

            if (trig_hit)
               remaining <= post_count;
            else if ((state_q == S_POST) && qual)
               remaining <= remaining - 1'b1;

            if (wr_en) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (count == FULL) begin
                  // Buffer full: the new entry overwrites the oldest one.
                  rd_ptr <= rd_ptr + 1'b1;
                  if (dropped != CYC_MAX) dropped <= dropped + 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end else if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
               count  <= count - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_trace.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_trace
//
// Directed bench for cpu_bus_trace. Stimulus tasks push the entries they
// expect to read back into exp_q; an independent monitor pops and compares on
// every rd_valid. Status outputs are checked directly after the clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_bus_trace;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 16;
   localparam int CYC_W   = 16;
   localparam int ENTRY_W = CYC_W + ADDR_W + DATA_W + 2;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PRE  = 2'd1;
   localparam logic [1:0] ST_POST = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [ADDR_W-1:0]  addr_bus = '0;
   logic [DATA_W-1:0]  data_bus = '0;
   logic [DATA_W-1:0]  wr_data = '0;
   logic               mem_read = 1'b0;
   logic               mem_write = 1'b0;
   logic               halt = 1'b0;
   logic               arm = 1'b0;
   logic [1:0]         mode = '0;
   logic [ADDR_W-1:0]  trig_addr = '0;
   logic [ADDR_W-1:0]  trig_mask = '0;
   logic [CNT_W-1:0]   post_count = '0;
   logic [CYC_W-1:0]   timeout_limit = '0;
   logic               rd_en = 1'b0;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;
   logic [1:0]         state;
   logic [CNT_W-1:0]   count;
   logic [CYC_W-1:0]   dropped;
   logic               triggered;
   logic               halted;
   logic               timed_out;

   cpu_bus_trace #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CYC_W  (CYC_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .addr_bus      (addr_bus),
      .data_bus      (data_bus),
      .wr_data       (wr_data),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .halt          (halt),
      .arm           (arm),
      .mode          (mode),
      .trig_addr     (trig_addr),
      .trig_mask     (trig_mask),
      .post_count    (post_count),
      .timeout_limit (timeout_limit),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .state         (state),
      .count         (count),
      .dropped       (dropped),
      .triggered     (triggered),
      .halted        (halted),
      .timed_out     (timed_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [ENTRY_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [ENTRY_W-1:0] ent(input logic [CYC_W-1:0] c,
                                              input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] d,
                                              input logic wr, input logic rd);
      return {c, a, d, wr, rd};
   endfunction

   // Monitor: every rd_valid pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n && rd_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h with no entry expected", rd_data);
         end else begin
            check("pop_entry", rd_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      halt      = 1'b0;
      arm       = 1'b0;
      rd_en     = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [ADDR_W-1:0] ta,
                         input logic [ADDR_W-1:0] tm, input logic [CNT_W-1:0] pc,
                         input logic [CYC_W-1:0] tl);
      mode          = m;
      trig_addr     = ta;
      trig_mask     = tm;
      post_count    = pc;
      timeout_limit = tl;
      arm = 1'b1;
      cycle();
      arm = 1'b0;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      mem_read = 1'b1;
      addr_bus = a;
      data_bus = d;
      cycle();
      mem_read = 1'b0;
   endtask

   task automatic halt_cycle();
      halt = 1'b1;
      cycle();
      halt = 1'b0;
   endtask

   task automatic pop_all(input string name);
      for (int k = 0; k < DEPTH + 4 && count != '0; k++) begin
         rd_en = 1'b1;
         cycle();
      end
      rd_en = 1'b0;
      cycle();
      cycle();
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_count0"}, count, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_bus();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", state, ST_IDLE);
      check("reset_count", count, 0);
      check("reset_flags", {triggered, halted, timed_out, rd_valid}, 0);
      #3 reset_n = 1'b1;
      cycle();

      // 1: single write at cyc 1, trigger on any address, halt at cyc 5
      do_arm(2'd3, 16'h0000, 16'h0000, 5'd4, 16'd0);
      cycle();                          // cyc 0: no traffic
      mem_write = 1'b1;
      addr_bus  = 16'h0100;
      wr_data   = 8'h5F;
      data_bus  = 8'hEE;
      cycle();                          // cyc 1
      mem_write = 1'b0;
      exp_q.push_back(ent(16'd1, 16'h0100, 8'h5F, 1'b1, 1'b0));
      check("t1_post", state, ST_POST);
      repeat (3) cycle();               // cyc 2..4
      halt_cycle();                     // cyc 5
      check("t1_done", state, ST_DONE);
      check("t1_flags", {triggered, halted, timed_out}, 3'b110);
      check("t1_count", count, 1);
      pop_all("t1");
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      check("t1_empty_pop", rd_valid, 0);
      cycle();

      // 2: reads 0..6, trigger at 4, two more after it
      do_arm(2'd1, 16'h0004, 16'hFFFF, 5'd2, 16'd0);
      for (int i = 0; i < 7; i++) begin
         bus_read(16'(i), 8'(8'h10 + i));
         exp_q.push_back(ent(16'(i), 16'(i), 8'(8'h10 + i), 1'b0, 1'b1));
         if (i == 3) check("t2_pre", state, ST_PRE);
         if (i == 5) check("t2_still_post", state, ST_POST);
      end
      check("t2_done", state, ST_DONE);
      check("t2_count", count, 7);
      check("t2_dropped", dropped, 0);
      check("t2_flags", {triggered, halted, timed_out}, 3'b100);
      pop_all("t2");

      // 3: overflow, 20 reads and no trigger
      do_arm(2'd1, 16'hFFFF, 16'hFFFF, 5'd1, 16'd0);
      for (int i = 0; i < 20; i++) begin
         bus_read(16'(16'h0200 + i), 8'(i));
         if (i >= 4) exp_q.push_back(ent(16'(i), 16'(16'h0200 + i), 8'(i), 1'b0, 1'b1));
      end
      halt_cycle();
      check("t3_done", state, ST_DONE);
      check("t3_count", count, 16);
      check("t3_dropped", dropped, 4);
      check("t3_flags", {triggered, halted, timed_out}, 3'b010);
      pop_all("t3");

      // 4: watchdog with no bus traffic
      do_arm(2'd3, 16'h0000, 16'hFFFF, 5'd1, 16'd10);
      repeat (10) cycle();              // cyc 0..9
      check("t4_not_yet", state, ST_PRE);
      cycle();                          // cyc 10
      check("t4_done", state, ST_DONE);
      check("t4_flags", {triggered, halted, timed_out}, 3'b001);
      check("t4_count", count, 0);

      // 5: trigger and halt on the same cycle
      do_arm(2'd3, 16'h0300, 16'hFFFF, 5'd3, 16'd0);
      halt = 1'b1;
      bus_read(16'h0300, 8'hC3);
      halt = 1'b0;
      exp_q.push_back(ent(16'd0, 16'h0300, 8'hC3, 1'b0, 1'b1));
      check("t5_done", state, ST_DONE);
      check("t5_flags", {triggered, halted, timed_out}, 3'b110);
      check("t5_count", count, 1);
      pop_all("t5");

      // 6: reset in the middle of POST, then re-arm
      do_arm(2'd1, 16'h0004, 16'hFFFF, 5'd5, 16'd0);
      for (int i = 0; i < 5; i++) bus_read(16'(i), 8'(i));
      check("t6_post", state, ST_POST);
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_state", state, ST_IDLE);
      check("t6_rst_count", count, 0);
      check("t6_rst_dropped", dropped, 0);
      check("t6_rst_flags", {triggered, halted, timed_out, rd_valid}, 0);
      check("t6_rst_data", rd_data, 0);
      reset_n = 1'b1;
      cycle();
      do_arm(2'd1, 16'h0004, 16'hFFFF, 5'd5, 16'd0);
      bus_read(16'h0040, 8'hA5);
      exp_q.push_back(ent(16'd0, 16'h0040, 8'hA5, 1'b0, 1'b1));
      bus_read(16'h0041, 8'h5A);
      exp_q.push_back(ent(16'd1, 16'h0041, 8'h5A, 1'b0, 1'b1));
      halt_cycle();
      check("t6_done", state, ST_DONE);
      check("t6_count", count, 2);
      pop_all("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_bus_trace.md
Name: cpu_bus_trace

Overview:
- Parametrised on-chip bus trace buffer that snoops the cpu_top memory bus (address, data, mem_read/mem_write, halt).
- Captures qualified bus cycles with cycle timestamps into a circular buffer, with address trigger, post-trigger count, halt stop and timeout watchdog.
- Frozen trace is read out oldest-first; used by the simulation monitor and by FPGA debug builds.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- DEPTH, 16, buffer entries (power of 2, >=2)
- CYC_W, 16, timestamp/cycle counter width
- ENTRY_W, CYC_W+ADDR_W+DATA_W+2, derived entry width: {cyc, addr, data, wr, rd}

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- addr_bus  in  ADDR_W  CPU address bus
- data_bus  in  DATA_W  memory read data (valid when mem_read)
- wr_data  in  DATA_W  CPU write data (acc_out)
- mem_read  in  1  read strobe
- mem_write  in  1  write strobe
- halt  in  1  CPU halt
- arm  in  1  one-cycle start pulse
- mode  in  2  bit0 capture reads, bit1 capture writes
- trig_addr  in  ADDR_W  trigger address
- trig_mask  in  ADDR_W  compare mask (1 = bit compared)
- post_count  in  $clog2(DEPTH)+1  entries to capture after trigger
- timeout_limit  in  CYC_W  watchdog limit, 0 = disabled
- rd_en  in  1  pop request
- rd_data  out  ENTRY_W  popped entry
- rd_valid  out  1  rd_data valid pulse
- state  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE
- count  out  $clog2(DEPTH)+1  entries held
- dropped  out  CYC_W  entries overwritten, saturating
- triggered, halted, timed_out  out  1 each  DONE cause flags

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (reset_n). On reset all outputs are 0: state IDLE, count 0, dropped 0, flags 0, rd_valid 0, rd_data 0. Buffer pointers and cycle counter are cleared.
- Arm: arm=1 in IDLE or DONE clears pointers, count, dropped, flags and cycle counter, then enters PRE next cycle. Arm in PRE/POST is ignored.
- Qualify: qual = (mem_read & mode[0]) | (mem_write & mode[1]).
- Captured data: wr_data if mem_write, else data_bus.
- Entry: {cyc, addr_bus, data, mem_write, mem_read}.
- Cycle counter cyc: +1 every clk in PRE/POST, saturates at all-ones. The entry holds the pre-increment value; the first cycle after arm stamps 0.
- PRE/POST write: each qual cycle writes at wr_ptr. If count==DEPTH, the oldest entry is overwritten (rd_ptr advances), count stays DEPTH and dropped increments (saturating).
- PRE, trigger: qual & ((addr_bus^trig_addr)&trig_mask)==0. The triggering entry is written, triggered<=1 and remaining<=post_count. If post_count==0 go DONE, else go POST.
- POST: each qual write decrements remaining. Reaching 0 goes DONE the same edge.
- Stops: halt=1 in PRE/POST enters DONE with halted=1; that cycle's qual entry is still written. If timeout_limit!=0 and cyc==timeout_limit in PRE/POST, enter DONE with timed_out=1. If several stop causes fire on one cycle, all their flags are set.
- DONE: no capture. rd_en with count>0 gives rd_data=oldest entry and rd_valid=1 on the next cycle, with rd_ptr++ and count--. rd_en with count==0 gives rd_valid=0. rd_en outside DONE is ignored.
- Pointers wrap modulo DEPTH. Reset mid-capture aborts immediately to IDLE with the buffer discarded.

Test Plan:
- Reset, arm, mode=3, trig_mask=0: at cyc 1 write 0x0100 data 0x5F, halt at cyc 5 -> DONE, halted=1, triggered=1, count=1, pop gives {1,0x0100,0x5F,1,0}, and a second pop gives rd_valid=0.
- mode=1, trig_addr=0x0004, mask=0xFFFF, post_count=2, reads 0x0000..0x0006 one per cycle -> DONE after 0x0006, count=7, dropped=0, and entries pop in order 0x0000..0x0006.
- DEPTH=16, 20 qualifying reads with no trigger, then halt -> count=16, dropped=4, first pop addr = 5th read.
- timeout_limit=10, no bus traffic -> DONE when cyc=10, timed_out=1, count=0.
- Halt and trigger on the same cycle with post_count=3 -> DONE, triggered=1, halted=1, and the entry is captured.
- Assert reset_n low mid-POST -> all outputs 0 asynchronously. Re-arm -> stamps restart at 0.
